score_keeper: RTL and testbench

Scoring FSM for the pong datapath. It consumes the ball x-position published once per frame by the ball controller and detects when the ball leaves the court at either side wall. It keeps both players' 4-bit scores, declares the match winner and gates the serve input. Its outputs drive the score display and the serve logic.

---
 rtl/score_keeper.sv | 129 ++++++++++++
 tb/tb_score_keeper.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - pong scoring FSM: wall-exit detection, scores, winner and serve gating
module score_keeper #(
    parameter int X_LEFT_LIMIT  = 6,
    parameter int X_RIGHT_LIMIT = 1017,
    parameter int WIN_POINTS    = 11,
    parameter int HOLD_FRAMES   = 60
) (
    input  logic        clk65MHz,
    input  logic        rst,
    input  logic        end_of_frame,
    input  logic        screen_idle,
    input  logic [10:0] x_pos_of_ball,
    output logic [3:0]  points_player_1,
    output logic [3:0]  points_player_2,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        serve_enable
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [10:0] X_LEFT    = 11'(X_LEFT_LIMIT);
    localparam logic [10:0] X_RIGHT   = 11'(X_RIGHT_LIMIT);
    localparam logic [3:0]  WIN       = 4'(WIN_POINTS);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);

    state_t      state, state_n;
    logic [3:0]  p1_n, p2_n;
    logic [3:0]  p1_inc, p2_inc;
    logic [1:0]  winner_n;
    logic [7:0]  hold_cnt, hold_cnt_n;
    logic        game_over_n, serve_enable_n;
    logic        hit_left, hit_right, centred;

    assign hit_right = x_pos_of_ball >= X_RIGHT;
    assign hit_left  = x_pos_of_ball <= X_LEFT;
    assign centred   = (x_pos_of_ball > X_LEFT) && (x_pos_of_ball < X_RIGHT);
    assign p1_inc    = points_player_1 + 4'd1;
    assign p2_inc    = points_player_2 + 4'd1;

    always_comb begin
        state_n    = state;
        p1_n       = points_player_1;
        p2_n       = points_player_2;
        winner_n   = winner;
        hold_cnt_n = hold_cnt;

        if (screen_idle) begin
            // Menu screen overrides everything, including a point scored this cycle.
            state_n    = IDLE;
            p1_n       = 4'd0;
            p2_n       = 4'd0;
            winner_n   = 2'd0;
            hold_cnt_n = 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = PLAY;
                end
                PLAY: begin
                    // Right wall is checked first so it wins if both ever hold.
                    if (end_of_frame && hit_right) begin
                        p2_n = p2_inc;
                        if (p2_inc == WIN) begin
                            state_n  = OVER;
                            winner_n = 2'd2;
                        end else begin
                            state_n    = HOLD;
                            hold_cnt_n = 8'd0;
                        end
                    end else if (end_of_frame && hit_left) begin
                        p1_n = p1_inc;
                        if (p1_inc == WIN) begin
                            state_n  = OVER;
                            winner_n = 2'd1;
                        end else begin
                            state_n    = HOLD;
                            hold_cnt_n = 8'd0;
                        end
                    end
                end
                HOLD: begin
                    if (end_of_frame) begin
                        if (hold_cnt >= HOLD_LAST && centred) begin
                            state_n = PLAY;
                        end else if (hold_cnt < HOLD_LAST) begin
                            hold_cnt_n = hold_cnt + 8'd1;
                        end
                    end
                end
                OVER: begin
                    state_n = OVER;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end

        game_over_n    = (state_n == OVER);
        serve_enable_n = (state_n == PLAY);
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state           <= IDLE;
            points_player_1 <= 4'd0;
            points_player_2 <= 4'd0;
            winner          <= 2'd0;
            hold_cnt        <= 8'd0;
            game_over       <= 1'b0;
            serve_enable    <= 1'b0;
        end else begin
            state           <= state_n;
            points_player_1 <= p1_n;
            points_player_2 <= p2_n;
            winner          <= winner_n;
            hold_cnt        <= hold_cnt_n;
            game_over       <= game_over_n;
            serve_enable    <= serve_enable_n;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - randomized and directed bench for score_keeper against a match-level model
module tb_score_keeper;

    logic        clk65MHz = 1'b0;
    logic        rst = 1'b1;
    logic        end_of_frame = 1'b0;
    logic        screen_idle = 1'b1;
    logic [10:0] x_pos_of_ball = 11'd504;
    logic [3:0]  points_player_1;
    logic [3:0]  points_player_2;
    logic [1:0]  winner;
    logic        game_over;
    logic        serve_enable;

    score_keeper dut (
        .clk65MHz        (clk65MHz),
        .rst             (rst),
        .end_of_frame    (end_of_frame),
        .screen_idle     (screen_idle),
        .x_pos_of_ball   (x_pos_of_ball),
        .points_player_1 (points_player_1),
        .points_player_2 (points_player_2),
        .winner          (winner),
        .game_over       (game_over),
        .serve_enable    (serve_enable)
    );

    always #5 clk65MHz = ~clk65MHz;

    // Match-level reference: phase of the rally plus plain score arithmetic.
    localparam int LEFT = 6, RIGHT = 1017, WIN_AT = 11, DEAD_FRAMES = 60;
    string m_phase = "idle";
    int    m_score[1:2] = '{0, 0};
    int    m_winner = 0;
    int    m_frames_waited = 0;

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed == expected) n_passed++;
        else $display("FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    endtask

    task automatic model_step(input bit r, input bit si, input bit eof, input int x);
        int scorer;
        if (r || si) begin
            m_phase = "idle";
            m_score[1] = 0;
            m_score[2] = 0;
            m_winner = 0;
            m_frames_waited = 0;
            return;
        end
        if (m_phase == "idle") begin
            m_phase = "play";
        end else if (m_phase == "play" && eof) begin
            scorer = (x >= RIGHT) ? 2 : (x <= LEFT) ? 1 : 0;
            if (scorer != 0) begin
                m_score[scorer] = m_score[scorer] + 1;
                if (m_score[scorer] == WIN_AT) begin
                    m_phase = "over";
                    m_winner = scorer;
                end else begin
                    m_phase = "hold";
                    m_frames_waited = 0;
                end
            end
        end else if (m_phase == "hold" && eof) begin
            if (m_frames_waited + 1 >= DEAD_FRAMES && x > LEFT && x < RIGHT) m_phase = "play";
            else m_frames_waited++;
        end
    endtask

    task automatic tick(input bit r, input bit si, input bit eof, input int x);
        rst = r;
        screen_idle = si;
        end_of_frame = eof;
        x_pos_of_ball = 11'(x);
        @(posedge clk65MHz);
        model_step(r, si, eof, x);
        #1;
        check("p1", int'(points_player_1), m_score[1]);
        check("p2", int'(points_player_2), m_score[2]);
        check("winner", int'(winner), m_winner);
        check("game_over", int'(game_over), int'(m_phase == "over"));
        check("serve_enable", int'(serve_enable), int'(m_phase == "play"));
    endtask

    task automatic recentre();
        for (int i = 0; i < DEAD_FRAMES; i++) tick(0, 0, 1, 504);
    endtask

    int rx;
    bit rs, rr, re;

    initial begin
        tick(1, 1, 0, 504);
        tick(1, 0, 0, 504);
        check("reset_serve", int'(serve_enable), 0);

        // Start a match and score on the right wall.
        tick(0, 0, 0, 504);
        check("play_serve", int'(serve_enable), 1);
        tick(0, 0, 1, 1020);
        check("p2_first_point", int'(points_player_2), 1);
        check("hold_serve_off", int'(serve_enable), 0);
        for (int i = 0; i < 100; i++) tick(0, 0, 1, 1020);
        check("no_double_count", int'(points_player_2), 1);
        tick(0, 0, 1, 504);
        check("recentred_play", int'(serve_enable), 1);

        // Exact-limit behaviour.
        tick(0, 0, 1, 1016);
        tick(0, 0, 1, 7);
        check("inside_limits", int'(points_player_1) + int'(points_player_2), 1);
        tick(0, 0, 1, 1017);
        check("right_limit", int'(points_player_2), 2);
        // One frame short of the dead time must still leave serve disabled.
        for (int i = 0; i < DEAD_FRAMES - 1; i++) tick(0, 0, 1, 504);
        check("hold_min_frames", int'(serve_enable), 0);
        tick(0, 0, 1, 504);
        check("hold_exit", int'(serve_enable), 1);
        tick(0, 0, 1, 6);
        check("left_limit", int'(points_player_1), 1);
        recentre();

        // Ball parked at a wall with no frame pulse.
        for (int i = 0; i < 1000; i++) tick(0, 0, 0, 1020);

        // Player 1 runs out the match.
        for (int i = 0; i < 11; i++) begin
            tick(0, 0, 1, 3);
            recentre();
        end
        check("p1_wins_score", int'(points_player_1), 11);
        check("p1_wins_winner", int'(winner), 1);
        check("p1_wins_over", int'(game_over), 1);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 3);
        check("frozen_score", int'(points_player_1), 11);

        // screen_idle beats a simultaneous point.
        tick(0, 1, 0, 504);
        tick(0, 0, 0, 504);
        tick(0, 1, 1, 1020);
        check("idle_no_inc", int'(points_player_2), 0);
        tick(0, 0, 0, 504);
        tick(0, 0, 1, 2);
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 504);
        tick(1, 0, 0, 504);
        check("rst_mid_hold", int'(points_player_1), 0);
        tick(0, 0, 0, 504);

        // Randomized play with a bias towards walls and limit values.
        for (int i = 0; i < 6000; i++) begin
            case ($urandom_range(0, 5))
                0: rx = int'($urandom_range(0, 6));
                1: rx = int'($urandom_range(1017, 2047));
                2: rx = 504;
                3: rx = int'($urandom_range(7, 1016));
                4: rx = ($urandom_range(0, 1) != 0) ? 6 : 1017;
                default: rx = ($urandom_range(0, 1) != 0) ? 7 : 1016;
            endcase
            re = ($urandom_range(0, 1) != 0);
            rs = ($urandom_range(0, 399) == 0);
            rr = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 1) != 0) rx = 504;
            tick(rr, rs, re, rx);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
